// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dm_arb_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DBG  = 2'b10
    } owner_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester and memory-side bus of the data-memory arbiter.
interface dm_arbiter_if #(
    parameter int AW = dm_arb_pkg::AW_DEF,
    parameter int DW = dm_arb_pkg::DW_DEF
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_lock;

    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  mem_q,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_a, mem_d, mem_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output mem_q,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_a, mem_d, mem_we
    );
endinterface

// File: rtl/dm_arbiter_starve_ctr.sv
// CPU starvation guard: counts consecutive denied CPU cycles and
// flags force_cpu once MAX_WAIT is reached.
module arb_starve_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic cpu_gnt,
    input  logic dbg_lock,
    output logic force_cpu
);
    logic [3:0] wait_q, wait_d;

    always_comb begin
        wait_d = wait_q;
        if (!cpu_req || cpu_gnt || dbg_lock)
            wait_d = '0;
        else if (wait_q != 4'(MAX_WAIT))
            wait_d = wait_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wait_q <= '0;
        else     wait_q <= wait_d;
    end

    // Taken from the register so the grant path has no loop through cpu_gnt.
    assign force_cpu = (wait_q == 4'(MAX_WAIT));
endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the single-port data memory: debug priority,
// CPU starvation guard, debug lock, and one-cycle read-data return routing.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    dm_arbiter_if.slave bus,
    output logic [15:0] cpu_stall_cnt
);
    logic          cpu_win, dbg_win, force_cpu;
    owner_e        rd_owner_q, rd_owner_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [15:0]   stall_q, stall_d;
    logic [AW-1:0] mem_a_d;
    logic [DW-1:0] mem_d_d;

    arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (bus.cpu_req),
        .cpu_gnt   (cpu_win),
        .dbg_lock  (bus.dbg_lock),
        .force_cpu (force_cpu)
    );

    always_comb begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (rst) begin
            cpu_win = 1'b0;
        end else if (bus.dbg_lock) begin
            dbg_win = bus.dbg_req;
        end else if (force_cpu && bus.cpu_req) begin
            cpu_win = 1'b1;
        end else if (bus.dbg_req) begin
            dbg_win = 1'b1;
        end else if (bus.cpu_req) begin
            cpu_win = 1'b1;
        end
    end

    // Idle bus parks on the debug address/data.
    always_comb begin
        mem_a_d = cpu_win ? bus.cpu_addr  : bus.dbg_addr;
        mem_d_d = cpu_win ? bus.cpu_wdata : bus.dbg_wdata;
        if (rst) begin
            mem_a_d = '0;
            mem_d_d = '0;
        end
    end

    assign bus.cpu_gnt = cpu_win;
    assign bus.dbg_gnt = dbg_win;
    assign bus.mem_a   = mem_a_d;
    assign bus.mem_d   = mem_d_d;
    assign bus.mem_we  = (cpu_win & bus.cpu_we) | (dbg_win & bus.dbg_we);

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (cpu_win && !bus.cpu_we)      rd_owner_d = OWN_CPU;
        else if (dbg_win && !bus.dbg_we) rd_owner_d = OWN_DBG;
    end

    // Owner sees mem_q live; the other port keeps its last returned word.
    always_comb begin
        cpu_rdata_d = (rd_owner_q == OWN_CPU) ? bus.mem_q : cpu_rdata_q;
        dbg_rdata_d = (rd_owner_q == OWN_DBG) ? bus.mem_q : dbg_rdata_q;
    end

    assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
    assign bus.dbg_rvalid = (rd_owner_q == OWN_DBG);
    assign bus.cpu_rdata  = cpu_rdata_d;
    assign bus.dbg_rdata  = dbg_rdata_d;

    always_comb begin
        stall_d = stall_q;
        if (bus.cpu_req && !cpu_win && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    assign cpu_stall_cnt = stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner_q  <= OWN_NONE;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            stall_q     <= '0;
        end else begin
            rd_owner_q  <= rd_owner_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            stall_q     <= stall_d;
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: behavioural scoreboard checked every cycle
// plus hand-computed expectations for each scenario.
module tb_dm_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        rst;
    logic [15:0] stall;

    int n_checks = 0;
    int n_fail   = 0;

    dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dm_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .cpu_stall_cnt (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first synchronous single-port memory.
    logic [DW-1:0] tmem [0:1023] = '{default: '0};
    always @(posedge clk) begin
        if (bus.mem_we) tmem[bus.mem_a] <= bus.mem_d;
        bus.mem_q <= bus.mem_we ? bus.mem_d : tmem[bus.mem_a];
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] ref_mem [0:1023] = '{default: '0};
    int            denied;
    int            m_stall;
    int            pend_own;
    logic [DW-1:0] pend_data, cpu_hold, dbg_hold;
    bit            cg, dg, e_we, cpu_rv, dbg_rv;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;

    initial begin
        denied = 0; m_stall = 0; pend_own = 0;
        pend_data = '0; cpu_hold = '0; dbg_hold = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_cpu_gnt",  64'(bus.cpu_gnt),    64'd0);
                check("rst_dbg_gnt",  64'(bus.dbg_gnt),    64'd0);
                check("rst_mem_we",   64'(bus.mem_we),     64'd0);
                check("rst_mem_a",    64'(bus.mem_a),      64'd0);
                check("rst_mem_d",    64'(bus.mem_d),      64'd0);
                check("rst_cpu_rv",   64'(bus.cpu_rvalid), 64'd0);
                check("rst_dbg_rv",   64'(bus.dbg_rvalid), 64'd0);
                check("rst_cpu_rd",   64'(bus.cpu_rdata),  64'd0);
                check("rst_dbg_rd",   64'(bus.dbg_rdata),  64'd0);
                check("rst_stall",    64'(stall),          64'd0);
                denied = 0; m_stall = 0; pend_own = 0;
                cpu_hold = '0; dbg_hold = '0;
            end else begin
                cg = 1'b0; dg = 1'b0;
                if (bus.dbg_lock)                           dg = bus.dbg_req;
                else if (bus.cpu_req && denied >= MAX_WAIT) cg = 1'b1;
                else if (bus.dbg_req)                       dg = 1'b1;
                else if (bus.cpu_req)                       cg = 1'b1;
                e_we   = cg ? bus.cpu_we : (dg ? bus.dbg_we : 1'b0);
                ea     = cg ? bus.cpu_addr  : bus.dbg_addr;
                ed     = cg ? bus.cpu_wdata : bus.dbg_wdata;
                cpu_rv = (pend_own == 1);
                dbg_rv = (pend_own == 2);
                check("m_cpu_gnt", 64'(bus.cpu_gnt),    64'(cg));
                check("m_dbg_gnt", 64'(bus.dbg_gnt),    64'(dg));
                check("m_mem_we",  64'(bus.mem_we),     64'(e_we));
                check("m_mem_a",   64'(bus.mem_a),      64'(ea));
                check("m_mem_d",   64'(bus.mem_d),      64'(ed));
                check("m_cpu_rv",  64'(bus.cpu_rvalid), 64'(cpu_rv));
                check("m_dbg_rv",  64'(bus.dbg_rvalid), 64'(dbg_rv));
                check("m_cpu_rd",  64'(bus.cpu_rdata),  64'(cpu_rv ? pend_data : cpu_hold));
                check("m_dbg_rd",  64'(bus.dbg_rdata),  64'(dbg_rv ? pend_data : dbg_hold));
                check("m_stall",   64'(stall),          64'(m_stall));
                if (cpu_rv) cpu_hold = pend_data;
                if (dbg_rv) dbg_hold = pend_data;
                pend_own = 0;
                if (cg || dg) begin
                    if (e_we) ref_mem[ea] = ed;
                    else begin
                        pend_own  = cg ? 1 : 2;
                        pend_data = ref_mem[ea];
                    end
                end
                if (bus.cpu_req && !cg && m_stall < 65535) m_stall++;
                if (bus.cpu_req && !cg && !bus.dbg_lock) denied++;
                else denied = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input bit dr, input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                       input bit lk);
        bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.dbg_req = dr; bus.dbg_we = dw; bus.dbg_addr = da; bus.dbg_wdata = dd;
        bus.dbg_lock = lk;
    endtask

    task automatic idle();
        drv(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    logic [AW-1:0] pa [5];
    logic [DW-1:0] pd [5];

    initial begin
        pa[0] = 10'h010; pd[0] = 32'hDEADBEEF;
        pa[1] = 10'h001; pd[1] = 32'hA1A1A1A1;
        pa[2] = 10'h002; pd[2] = 32'hB2B2B2B2;
        pa[3] = 10'h003; pd[3] = 32'hC3C3C3C3;
        pa[4] = 10'h030; pd[4] = 32'h30303030;

        rst = 1'b1;
        drv(0, 0, '0, '0, 1, 1, 10'h3FF, 32'h1234, 0);
        #12;
        check("reset_dbg_gnt", 64'(bus.dbg_gnt), 64'd0);
        check("reset_mem_we",  64'(bus.mem_we),  64'd0);
        check("reset_mem_a",   64'(bus.mem_a),   64'd0);
        tick();
        rst = 1'b0;
        idle();

        // loader preload through the debug port
        for (int i = 0; i < 5; i++) begin
            drv(0, 0, '0, '0, 1, 1, pa[i], pd[i], 0);
            tick();
        end

        // CPU read alone
        drv(1, 0, 10'h010, '0, 0, 0, '0, '0, 0);
        look();
        check("t1_cpu_gnt", 64'(bus.cpu_gnt), 64'd1);
        check("t1_mem_a",   64'(bus.mem_a),   64'h010);
        tick();
        idle();
        look();
        check("t1_cpu_rv",  64'(bus.cpu_rvalid), 64'd1);
        check("t1_cpu_rd",  64'(bus.cpu_rdata),  64'hDEADBEEF);
        check("t1_dbg_rv",  64'(bus.dbg_rvalid), 64'd0);
        tick();

        // simultaneous dbg write + CPU read
        drv(1, 0, 10'h030, '0, 1, 1, 10'h020, 32'h55, 0);
        look();
        check("t2_dbg_gnt", 64'(bus.dbg_gnt), 64'd1);
        check("t2_mem_we",  64'(bus.mem_we),  64'd1);
        check("t2_cpu_gnt", 64'(bus.cpu_gnt), 64'd0);
        tick();
        drv(1, 0, 10'h030, '0, 0, 0, 10'h020, '0, 0);
        look();
        check("t2_cpu_gnt1", 64'(bus.cpu_gnt), 64'd1);
        check("t2_stall",    64'(stall),       64'd1);
        tick();
        idle();
        look();
        check("t2_cpu_rd",   64'(bus.cpu_rdata), 64'h30303030);
        tick();

        // starvation: both held, CPU forced every fifth cycle
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            drv(1, 0, 10'h030, '0, 1, 0, 10'(1 + i % 3), '0, 0);
            look();
            check("t3_cpu_gnt", 64'(bus.cpu_gnt), 64'((i % 5) == 4));
            check("t3_dbg_gnt", 64'(bus.dbg_gnt), 64'((i % 5) != 4));
            tick();
        end
        idle();
        look();
        check("t3_stall",  64'(stall),          64'd8);
        check("t3_cpu_rv", 64'(bus.cpu_rvalid), 64'd1);
        tick();

        // lock shuts the CPU out
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            drv(1, 0, 10'h002, '0, 0, 0, '0, '0, 1);
            look();
            check("t4_cpu_gnt_lock", 64'(bus.cpu_gnt), 64'd0);
            tick();
        end
        drv(1, 0, 10'h002, '0, 0, 0, '0, '0, 0);
        look();
        check("t4_cpu_gnt_rel", 64'(bus.cpu_gnt), 64'd1);
        check("t4_stall",       64'(stall),       64'd20);
        tick();
        idle();
        look();
        check("t4_cpu_rd", 64'(bus.cpu_rdata), 64'hB2B2B2B2);
        tick();

        // interleaved back-to-back reads, lock rising with CPU read in flight
        drv(0, 0, '0, '0, 1, 0, 10'h001, '0, 0);
        tick();
        drv(1, 0, 10'h002, '0, 0, 0, '0, '0, 0);
        look();
        check("t5_dbg_rv0", 64'(bus.dbg_rvalid), 64'd1);
        check("t5_dbg_rd0", 64'(bus.dbg_rdata),  64'hA1A1A1A1);
        tick();
        drv(0, 0, '0, '0, 1, 0, 10'h003, '0, 0);
        look();
        check("t5_cpu_rv",  64'(bus.cpu_rvalid), 64'd1);
        check("t5_cpu_rd",  64'(bus.cpu_rdata),  64'hB2B2B2B2);
        check("t5_dbg_rvx", 64'(bus.dbg_rvalid), 64'd0);
        tick();
        drv(1, 0, 10'h010, '0, 0, 0, '0, '0, 0);
        look();
        check("t5_dbg_rv1", 64'(bus.dbg_rvalid), 64'd1);
        check("t5_dbg_rd1", 64'(bus.dbg_rdata),  64'hC3C3C3C3);
        check("t5_cpu_hold",64'(bus.cpu_rdata),  64'hB2B2B2B2);
        tick();
        drv(0, 0, '0, '0, 0, 0, '0, '0, 1);
        look();
        check("t5_lock_rv", 64'(bus.cpu_rvalid), 64'd1);
        check("t5_lock_rd", 64'(bus.cpu_rdata),  64'hDEADBEEF);
        tick();

        // read-after-write through the memory
        drv(0, 0, '0, '0, 1, 1, 10'h040, 32'h12345678, 0);
        tick();
        drv(1, 0, 10'h040, '0, 0, 0, '0, '0, 0);
        tick();
        idle();
        look();
        check("raw_cpu_rd", 64'(bus.cpu_rdata), 64'h12345678);
        tick();

        // reset in the cycle after a debug read grant
        drv(1, 0, 10'h010, '0, 1, 1, 10'h050, 32'hABCD, 0);
        tick();
        drv(1, 0, 10'h010, '0, 0, 0, '0, '0, 0);
        tick();
        drv(0, 0, '0, '0, 1, 0, 10'h001, '0, 0);
        tick();
        rst = 1'b1;
        idle();
        look();
        check("t6_dbg_rv",  64'(bus.dbg_rvalid), 64'd0);
        check("t6_stall",   64'(stall),          64'd0);
        check("t6_dbg_rd",  64'(bus.dbg_rdata),  64'd0);
        tick();
        rst = 1'b0;
        drv(1, 0, 10'h010, '0, 0, 0, '0, '0, 0);
        look();
        check("t6_cpu_gnt", 64'(bus.cpu_gnt), 64'd1);
        tick();
        idle();
        look();
        check("t6_cpu_rd",  64'(bus.cpu_rdata), 64'hDEADBEEF);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Arbitrates the single-port data memory between two requesters: the CPU load/store path and the debug/loader port.
- Sits between the CPU datapath and the data memory. It replaces the static debug mux on the memory address, data and write-enable.
- Debug has fixed priority. A starvation counter forces a CPU grant after a bounded wait. A lock input shuts the CPU out entirely while debug mode is active.
- Read data returns one cycle after grant and is routed back to the owner that issued the read.

Parameters:
AW, 10, word-address width of data memory
DW, 32, data width
MAX_WAIT, 4, consecutive denied CPU-request cycles before the CPU is force-granted (range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, held until cpu_gnt
cpu_we  in  1  1=write, 0=read
cpu_addr  in  AW  CPU word address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  CPU access issued this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DW  CPU read data
dbg_req  in  1  debug access request, held until dbg_gnt
dbg_we  in  1  1=write, 0=read
dbg_addr  in  AW  debug word address
dbg_wdata  in  DW  debug write data
dbg_gnt  out  1  debug access issued this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  DW  debug read data
dbg_lock  in  1  1=CPU never granted (debug mode)
mem_a  out  AW  memory address
mem_d  out  DW  memory write data
mem_we  out  1  memory write enable
mem_q  in  DW  memory read data, valid the cycle after mem_a is presented
cpu_stall_cnt  out  16  saturating count of cycles with cpu_req=1 and cpu_gnt=0

Behaviour:
- Reset (async, rst=1):
  - wait_cnt=0, rd_owner=NONE, cpu_stall_cnt=0.
  - All gnt/rvalid outputs are 0; mem_we=0.
  - mem_a, mem_d and rdata outputs are 0.
- Grant is combinational in the same cycle as the request. At most one gnt per cycle.
  - Grant winner:
    - dbg_lock=1: dbg if dbg_req, else none.
    - wait_cnt==MAX_WAIT and cpu_req: cpu.
    - dbg_req: dbg.
    - cpu_req: cpu.
    - otherwise none.
  - mem_a and mem_d are taken from the winner; otherwise they hold dbg_addr and dbg_wdata.
  - mem_we = winner's we AND its gnt. mem_we is never asserted without a gnt.
- Starvation counter (4-bit, registered):
  - Increments when cpu_req=1, cpu_gnt=0 and dbg_lock=0.
  - Clears on cpu_gnt, and whenever cpu_req=0 or dbg_lock=1.
  - Saturates at MAX_WAIT.
- Read pipeline (registered rd_owner in {NONE, CPU, DBG}):
  - rd_owner is set the cycle after a read gnt, to the granted requester; otherwise NONE.
  - In the cycle after a read grant, that owner's rvalid=1 and its rdata=mem_q. The other port's rvalid=0 and its rdata is held.
  - Back-to-back reads from either port are supported at one access per cycle with no bubbles.
  - Writes never produce rvalid.
- Read-after-write: a write in cycle N followed by a read of the same address in cycle N+1 returns the new data. This follows from the memory's write-first behaviour; the arbiter adds no forwarding.
- A requester may drop req only after gnt. The arbiter does not check req drops without gnt.
- dbg_lock rising while a CPU read is in flight: that read's rvalid is still delivered the next cycle.
- cpu_stall_cnt increments on each stalled cycle, including dbg_lock cycles, and sticks at 16'hFFFF.
- Reset mid-operation: in-flight rvalid is discarded and counters clear. After release, the first cycle arbitrates fresh.

Decomposition:
- Shared package `dm_arb_pkg`:
  - owner enum OWN_NONE=2'b00, OWN_CPU=2'b01, OWN_DBG=2'b10.
  - Default AW/DW constants.
- Sub-module `arb_starve_ctr`: wait counter plus saturation compare, outputs force_cpu.
- Grant mux, read pipeline and stall counter stay in the top.

Test Plan:
- CPU read only: cpu_req=1, we=0, addr=0x010, mem holds 0xDEADBEEF.
  -> cpu_gnt same cycle; cpu_rvalid=1 with rdata=0xDEADBEEF next cycle; dbg_rvalid=0.
- Simultaneous requests: dbg write 0x55 to 0x020 and CPU read 0x030 together.
  -> dbg_gnt in cycle 0, mem_we=1; cpu_gnt in cycle 1; cpu_stall_cnt=1.
- Starvation, MAX_WAIT=4: dbg_req and cpu_req both held continuously.
  -> dbg granted cycles 0-3; cpu_gnt in cycle 4; dbg resumes cycle 5; pattern repeats every 5 cycles.
- Lock: dbg_lock=1, cpu_req held 20 cycles, dbg idle.
  -> cpu_gnt never asserts; wait_cnt stays 0; cpu_stall_cnt=20; releasing lock gives cpu_gnt the same cycle.
- Interleaved reads: dbg read 0x001, CPU read 0x002, dbg read 0x003 on consecutive cycles.
  -> rvalid pulses alternate dbg/cpu/dbg with matching data, no bubbles.
- Reset mid-read: rst pulses in the cycle after a dbg read gnt.
  -> dbg_rvalid stays 0; cpu_stall_cnt=0; outputs at reset values.
